// File: rtl/calc_pkg.sv
// Shared calculator definitions: ASCII codes used on the UART side and the
// result transmitter's state encoding.
package calc_pkg;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // Longest message is "-256\r\n".
  localparam int MSG_MAX = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/bcd_digit_extract.sv
// Repeated-subtraction binary-to-decimal converter for magnitudes 0..256:
// one subtraction per cycle, hundreds first, then tens; the remainder is ones.
module bcd_digit_extract #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         go,
  input  logic [W:0]   mag,
  output logic [1:0]   hund,
  output logic [3:0]   tens,
  output logic [3:0]   ones,
  output logic         valid
);

  localparam logic [W:0] C100 = (W+1)'(100);
  localparam logic [W:0] C10  = (W+1)'(10);

  logic [W:0] rem_q, rem_d;
  logic [1:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic       run_q, run_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rem_q  <= '0;
      hund_q <= '0;
      tens_q <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      run_q  <= run_d;
    end
  end

  always_comb begin
    rem_d  = rem_q;
    hund_d = hund_q;
    tens_d = tens_q;
    run_d  = run_q;
    if (go) begin
      rem_d  = mag;
      hund_d = '0;
      tens_d = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (rem_q >= C100) begin
        rem_d  = rem_q - C100;
        hund_d = hund_q + 2'd1;
      end else if (rem_q >= C10) begin
        rem_d  = rem_q - C10;
        tens_d = tens_q + 4'd1;
      end else begin
        run_d  = 1'b0;
      end
    end
  end

  // Digits are final as soon as the remainder drops below ten.
  assign valid = run_q && (rem_q < C10);
  assign hund  = hund_q;
  assign tens  = tens_q;
  assign ones  = rem_q[3:0];

endmodule

// File: rtl/result_tx.sv
// Prints a signed calculator result (or "ERR" on overflow) as ASCII decimal
// text, one byte per txclk strobe, paced by the UART's txready.
module result_tx
  import calc_pkg::*;
#(
  parameter int W         = 9,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [W-1:0] value,
  input  logic        o_flag,
  input  logic        txready,
  output logic [7:0]  txdata,
  output logic        txclk,
  output logic        busy,
  output logic        done,
  output tx_state_t   dbg_state
);

  tx_state_t  state_q, state_d;
  logic       sign_q, sign_d;
  logic [7:0] msg_q [MSG_MAX];
  logic [7:0] msg_d [MSG_MAX];
  logic [2:0] len_q, len_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] txdata_q, txdata_d;
  logic       txclk_q, txclk_d;

  logic       load;
  logic       err_sel;
  logic [2:0] n;
  logic       cvt_go;
  logic [W:0] sext;
  logic [W:0] mag_in;
  logic [1:0] hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       cvt_valid;

  // Sign-extend to W+1 bits so the most negative value has a representable magnitude.
  assign sext   = {value[W-1], value};
  assign mag_in = value[W-1] ? (~sext + (W+1)'(1)) : sext;
  assign cvt_go = (state_q == IDLE) && start && !o_flag;

  bcd_digit_extract #(.W(W)) u_bcd (
    .clk   (clk),
    .nrst  (nrst),
    .go    (cvt_go),
    .mag   (mag_in),
    .hund  (hund),
    .tens  (tens),
    .ones  (ones),
    .valid (cvt_valid)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      len_q    <= '0;
      idx_q    <= '0;
      txdata_q <= '0;
      txclk_q  <= 1'b0;
      for (int i = 0; i < MSG_MAX; i++) msg_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      for (int i = 0; i < MSG_MAX; i++) msg_q[i] <= msg_d[i];
    end
  end

  // Byte handshake: a byte is launched only when txready=1 and txclk was low
  // the previous cycle; txclk is then high for exactly one cycle with txdata
  // valid, so strobes are at least two cycles apart. txdata holds otherwise.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    idx_d    = idx_q;
    txdata_d = txdata_q;
    txclk_d  = 1'b0;
    load     = 1'b0;
    err_sel  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = value[W-1];
          if (o_flag) begin
            load    = 1'b1;
            err_sel = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end else begin
            state_d = CONV;
          end
        end
      end
      CONV: begin
        if (cvt_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (txclk_q && (idx_q == len_q)) begin
          state_d = FIN;
        end else if (txready && !txclk_q) begin
          txdata_d = msg_q[idx_q];
          txclk_d  = 1'b1;
          idx_d    = idx_q + 3'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Message builder: packs the text left-aligned into the buffer.
  always_comb begin
    for (int i = 0; i < MSG_MAX; i++) msg_d[i] = msg_q[i];
    len_d = len_q;
    n     = '0;
    if (load) begin
      for (int i = 0; i < MSG_MAX; i++) msg_d[i] = '0;
      if (err_sel) begin
        msg_d[0] = CH_E;
        msg_d[1] = CH_R;
        msg_d[2] = CH_R;
        n        = 3'd3;
      end else begin
        if (sign_q) begin
          msg_d[n] = CH_MINUS;
          n        = n + 3'd1;
        end
        if (hund != 2'd0) begin
          msg_d[n] = CH_ZERO + {6'd0, hund};
          n        = n + 3'd1;
        end
        if ((hund != 2'd0) || (tens != 4'd0)) begin
          msg_d[n] = CH_ZERO + {4'd0, tens};
          n        = n + 3'd1;
        end
        msg_d[n] = CH_ZERO + {4'd0, ones};
        n        = n + 3'd1;
      end
      if (SEND_CRLF) begin
        msg_d[n]        = CH_CR;
        msg_d[n + 3'd1] = CH_LF;
        n               = n + 3'd2;
      end
      len_d = n;
    end
  end

  assign txdata    = txdata_q;
  assign txclk     = txclk_q;
  assign busy      = (state_q == CONV) || (state_q == SEND);
  assign done      = (state_q == FIN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_result_tx.sv
// Directed bench for result_tx: table of results with expected ASCII text,
// plus stall, ignored-start and mid-message reset sequences.
module tb_result_tx;
  import calc_pkg::*;

  logic       clk;
  logic       nrst;
  logic       start;
  logic [8:0] value;
  logic       o_flag;
  logic       txready;
  logic [7:0] txdata;
  logic       txclk;
  logic       busy;
  logic       done;
  tx_state_t  dbg_state;

  result_tx #(.W(9), .SEND_CRLF(1'b1)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .value     (value),
    .o_flag    (o_flag),
    .txready   (txready),
    .txdata    (txdata),
    .txclk     (txclk),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_cmp    = 0;
  int n_err    = 0;
  int strobes  = 0;
  int done_cnt = 0;
  int conv_cnt = 0;
  logic prev_txclk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (txclk) begin
        strobes++;
        check("txclk_gap", {31'd0, prev_txclk}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", txdata, $time);
        end else begin
          check("byte", {24'd0, txdata}, {24'd0, exp_q.pop_front()});
        end
      end
      if (done) done_cnt++;
      if (dbg_state == CONV) conv_cnt++;
      prev_txclk = txclk;
    end else begin
      prev_txclk = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [8:0]  val;
    logic        oflag;
    int          len;
    logic [47:0] bytes;
  } vec_t;

  function automatic vec_t mk(input logic [8:0] v, input logic f, input int l, input logic [47:0] b);
    vec_t r;
    r.val = v; r.oflag = f; r.len = l; r.bytes = b;
    return r;
  endfunction

  task automatic push_expected(input vec_t v);
    for (int i = 0; i < v.len; i++) exp_q.push_back(v.bytes[47 - 8*i -: 8]);
  endtask

  task automatic pulse_start(input logic [8:0] v, input logic f);
    @(negedge clk);
    value  = v;
    o_flag = f;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    value  = 9'($urandom_range(0, 511));
    o_flag = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == 0) check({name, "_timeout"}, 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    done_cnt = 0;
    conv_cnt = 0;
    push_expected(v);
    pulse_start(v.val, v.oflag);
    wait_done("msg_done", 300);
    check("msg_all_bytes", exp_q.size(), 32'd0);
    check("done_once", done_cnt, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
    if (v.oflag) check("err_no_conv", conv_cnt, 32'd0);
    else         check("conv_bound", {31'd0, (conv_cnt >= 1 && conv_cnt <= 11)}, 32'd1);
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  vec_t vecs[10];
  logic [7:0] held;
  int s0;

  initial begin
    vecs[0] = mk(9'd0,   1'b0, 3, 48'h30_0D_0A_00_00_00);  // "0"
    vecs[1] = mk(9'd255, 1'b0, 5, 48'h32_35_35_0D_0A_00);  // "255"
    vecs[2] = mk(9'h100, 1'b0, 6, 48'h2D_32_35_36_0D_0A);  // "-256"
    vecs[3] = mk(9'h1F9, 1'b0, 4, 48'h2D_37_0D_0A_00_00);  // "-7"
    vecs[4] = mk(9'd105, 1'b0, 5, 48'h31_30_35_0D_0A_00);  // "105"
    vecs[5] = mk(9'd199, 1'b0, 5, 48'h31_39_39_0D_0A_00);  // "199"
    vecs[6] = mk(9'd10,  1'b0, 4, 48'h31_30_0D_0A_00_00);  // "10"
    vecs[7] = mk(9'h19C, 1'b0, 6, 48'h2D_31_30_30_0D_0A);  // "-100"
    vecs[8] = mk(9'h0AB, 1'b1, 5, 48'h45_52_52_0D_0A_00);  // "ERR"
    vecs[9] = mk(9'd100, 1'b0, 5, 48'h31_30_30_0D_0A_00);  // "100"

    nrst    = 1'b0;
    start   = 1'b0;
    value   = '0;
    o_flag  = 1'b0;
    txready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txdata", {24'd0, txdata}, 32'd0);
    check("rst_txclk",  {31'd0, txclk},  32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_state",  {30'd0, dbg_state}, {30'd0, IDLE});
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Stall for 20 cycles after two bytes of "255\r\n", then resume.
    done_cnt = 0;
    push_expected(vecs[1]);
    s0 = strobes;
    pulse_start(9'd255, 1'b0);
    for (int i = 0; i < 100 && strobes < s0 + 2; i++) @(negedge clk);
    check("stall_reach", strobes - s0, 32'd2);
    txready = 1'b0;
    held = txdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_txclk",  {31'd0, txclk}, 32'd0);
      check("stall_txdata", {24'd0, txdata}, {24'd0, held});
    end
    check("stall_busy", {31'd0, busy}, 32'd1);
    txready = 1'b1;
    wait_done("stall_done", 100);
    check("stall_all_bytes", exp_q.size(), 32'd0);
    check("stall_done_once", done_cnt, 32'd1);
    exp_q.delete();

    // Start pulsed while busy is ignored.
    done_cnt = 0;
    push_expected(vecs[1]);
    pulse_start(9'd255, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start(9'd42, 1'b0);
    wait_done("busy_done", 100);
    check("busy_all_bytes", exp_q.size(), 32'd0);
    check("busy_done_once", done_cnt, 32'd1);
    s0 = strobes;
    repeat (10) @(negedge clk);
    check("busy_no_requeue", strobes - s0, 32'd0);
    check("busy_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    exp_q.delete();

    // Reset mid-SEND aborts the message.
    push_expected(vecs[2]);
    s0 = strobes;
    pulse_start(9'h100, 1'b0);
    for (int i = 0; i < 100 && strobes < s0 + 1; i++) @(negedge clk);
    check("abort_reach", strobes - s0, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("abort_txdata", {24'd0, txdata}, 32'd0);
    check("abort_txclk",  {31'd0, txclk},  32'd0);
    check("abort_busy",   {31'd0, busy},   32'd0);
    check("abort_done",   {31'd0, done},   32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    s0 = strobes;
    repeat (20) @(negedge clk);
    check("abort_no_resume", strobes - s0, 32'd0);
    check("abort_idle", {30'd0, dbg_state}, {30'd0, IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
